char_renderer: RTL and testbench

- Scanline character renderer for the 800x600 text display.
- On each `start` pulse it produces one 800-pixel scanline:
  - reads 100 character cells from the character row buffer;
  - looks up each cell's font pattern row and its background/foreground palette colours;
  - writes the 800 resulting 12-bit RGB pixels into the pixel buffer at addresses 0..799.
- The pixel output stage then reads them during the next visible line.
- Sits between chrowbuf/fontmem/palette (upstream) and pixbuf (downstream); the parent issues `start` once per line.

---
 rtl/char_renderer.sv | 215 +++++++++++++++++++++
 tb/tb_char_renderer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_renderer.sv
// Scanline character renderer: fetches cell, font row and palette colours,
// then streams 8*NUM_COLS RGB pixels into the pixel buffer, one per clock.
module char_renderer #(
  parameter int unsigned NUM_COLS = 100
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic [3:0]  pixel_row,
  output logic        busy,
  output logic        done,
  output logic        chrowbuf_rd,
  output logic [7:0]  chrowbuf_rd_addr,
  input  logic [15:0] chrowbuf_rd_data,
  output logic        fontmem_rd,
  output logic [11:0] fontmem_rd_addr,
  input  logic [7:0]  fontmem_rd_data,
  output logic        palette_rd,
  output logic [7:0]  palette_rd_addr,
  input  logic [15:0] palette_rd_data,
  output logic        pixbuf_wr,
  output logic [9:0]  pixbuf_wr_addr,
  output logic [15:0] pixbuf_wr_data
);

  localparam int unsigned NUM_PIX  = 8 * NUM_COLS;
  localparam logic [9:0]  LAST_PIX = 10'(NUM_PIX - 1);
  localparam logic [7:0]  COLS     = 8'(NUM_COLS);
  localparam logic [2:0]  PRIME_END = 3'd5;

  typedef enum logic [1:0] {IDLE, PRIME, RENDER} state_t;

  state_t      state, state_d;
  logic [2:0]  step, step_d;
  logic [3:0]  row, row_d;
  logic [3:0]  fg_idx, fg_idx_d;
  logic [7:0]  pat_next, pat_next_d;
  logic [11:0] bg_next, bg_next_d;
  logic [11:0] fg_next, fg_next_d;
  logic [7:0]  pat_cur, pat_cur_d;
  logic [11:0] bg_cur, bg_cur_d;
  logic [11:0] fg_cur, fg_cur_d;

  logic        busy_d, done_d;
  logic        chrowbuf_rd_d, fontmem_rd_d, palette_rd_d, pixbuf_wr_d;
  logic [7:0]  chrowbuf_rd_addr_d;
  logic [11:0] fontmem_rd_addr_d;
  logic [7:0]  palette_rd_addr_d;
  logic [9:0]  pixbuf_wr_addr_d;
  logic [15:0] pixbuf_wr_data_d;

  logic [2:0]  phase_c;
  logic [7:0]  cell_c;
  logic        fetch_on_c;
  logic        unused_pal_hi;

  // Palette colour carries RGB in [11:0] only; upper nibble is don't-care.
  assign unused_pal_hi = ^palette_rd_data[15:12];

  // Fetch phase: PRIME step counter, or pixel slot within the current cell.
  assign phase_c    = (state == PRIME) ? step : pixbuf_wr_addr[2:0];
  assign cell_c     = {1'b0, pixbuf_wr_addr[9:3]};
  assign fetch_on_c = (state == PRIME) || ((cell_c + 8'd1) < COLS);

  // Next-state, datapath and registered-output inputs.
  always_comb begin
    state_d            = state;
    step_d             = step;
    row_d              = row;
    fg_idx_d           = fg_idx;
    pat_next_d         = pat_next;
    bg_next_d          = bg_next;
    fg_next_d          = fg_next;
    pat_cur_d          = pat_cur;
    bg_cur_d           = bg_cur;
    fg_cur_d           = fg_cur;
    busy_d             = busy;
    done_d             = 1'b0;
    chrowbuf_rd_d      = 1'b1;
    fontmem_rd_d       = 1'b1;
    palette_rd_d       = 1'b1;
    pixbuf_wr_d        = 1'b1;
    chrowbuf_rd_addr_d = chrowbuf_rd_addr;
    fontmem_rd_addr_d  = fontmem_rd_addr;
    palette_rd_addr_d  = palette_rd_addr;
    pixbuf_wr_addr_d   = pixbuf_wr_addr;
    pixbuf_wr_data_d   = pixbuf_wr_data;

    // Cell fetch pipeline, overlapped with pixel output of the previous cell.
    if (state != IDLE && fetch_on_c) begin
      case (phase_c)
        3'd1: begin
          fontmem_rd_d      = 1'b0;
          fontmem_rd_addr_d = {chrowbuf_rd_data[7:0], row};
          palette_rd_d      = 1'b0;
          palette_rd_addr_d = {4'h0, chrowbuf_rd_data[15:12]};
          fg_idx_d          = chrowbuf_rd_data[11:8];
        end
        3'd2: begin
          palette_rd_d      = 1'b0;
          palette_rd_addr_d = {4'h0, fg_idx};
        end
        3'd3: begin
          pat_next_d = fontmem_rd_data;
          bg_next_d  = palette_rd_data[11:0];
        end
        3'd4: fg_next_d = palette_rd_data[11:0];
        default: ;
      endcase
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_d            = PRIME;
          step_d             = 3'd0;
          row_d              = pixel_row;
          busy_d             = 1'b1;
          chrowbuf_rd_d      = 1'b0;
          chrowbuf_rd_addr_d = 8'd0;
        end
      end
      PRIME: begin
        step_d = step + 3'd1;
        if (step == PRIME_END) begin
          state_d          = RENDER;
          bg_cur_d         = bg_next;
          fg_cur_d         = fg_next;
          pat_cur_d        = {pat_next[6:0], 1'b0};
          pixbuf_wr_d      = 1'b0;
          pixbuf_wr_addr_d = 10'd0;
          pixbuf_wr_data_d = {4'h0, pat_next[7] ? fg_next : bg_next};
          if (COLS > 8'd1) begin
            chrowbuf_rd_d      = 1'b0;
            chrowbuf_rd_addr_d = 8'd1;
          end
        end
      end
      RENDER: begin
        if (pixbuf_wr_addr == LAST_PIX) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          pixbuf_wr_d      = 1'b0;
          pixbuf_wr_addr_d = pixbuf_wr_addr + 10'd1;
          if (pixbuf_wr_addr[2:0] == 3'd7) begin
            bg_cur_d         = bg_next;
            fg_cur_d         = fg_next;
            pat_cur_d        = {pat_next[6:0], 1'b0};
            pixbuf_wr_data_d = {4'h0, pat_next[7] ? fg_next : bg_next};
            if ((cell_c + 8'd2) < COLS) begin
              chrowbuf_rd_d      = 1'b0;
              chrowbuf_rd_addr_d = cell_c + 8'd2;
            end
          end else begin
            pat_cur_d        = {pat_cur[6:0], 1'b0};
            pixbuf_wr_data_d = {4'h0, pat_cur[7] ? fg_cur : bg_cur};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state            <= IDLE;
      step             <= 3'd0;
      row              <= 4'd0;
      fg_idx           <= 4'd0;
      pat_next         <= 8'd0;
      bg_next          <= 12'd0;
      fg_next          <= 12'd0;
      pat_cur          <= 8'd0;
      bg_cur           <= 12'd0;
      fg_cur           <= 12'd0;
      busy             <= 1'b0;
      done             <= 1'b0;
      chrowbuf_rd      <= 1'b1;
      fontmem_rd       <= 1'b1;
      palette_rd       <= 1'b1;
      pixbuf_wr        <= 1'b1;
      chrowbuf_rd_addr <= 8'd0;
      fontmem_rd_addr  <= 12'd0;
      palette_rd_addr  <= 8'd0;
      pixbuf_wr_addr   <= 10'd0;
      pixbuf_wr_data   <= 16'd0;
    end else begin
      state            <= state_d;
      step             <= step_d;
      row              <= row_d;
      fg_idx           <= fg_idx_d;
      pat_next         <= pat_next_d;
      bg_next          <= bg_next_d;
      fg_next          <= fg_next_d;
      pat_cur          <= pat_cur_d;
      bg_cur           <= bg_cur_d;
      fg_cur           <= fg_cur_d;
      busy             <= busy_d;
      done             <= done_d;
      chrowbuf_rd      <= chrowbuf_rd_d;
      fontmem_rd       <= fontmem_rd_d;
      palette_rd       <= palette_rd_d;
      pixbuf_wr        <= pixbuf_wr_d;
      chrowbuf_rd_addr <= chrowbuf_rd_addr_d;
      fontmem_rd_addr  <= fontmem_rd_addr_d;
      palette_rd_addr  <= palette_rd_addr_d;
      pixbuf_wr_addr   <= pixbuf_wr_addr_d;
      pixbuf_wr_data   <= pixbuf_wr_data_d;
    end
  end

endmodule

// File: tb/tb_char_renderer.sv
// Scoreboard bench for char_renderer: default-width instance plus a
// NUM_COLS=2 instance sharing the same memory contents.
module tb_char_renderer;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       start = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] pixel_row = 4'd0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared memory contents.
  logic [15:0] chr_mem  [256];
  logic [7:0]  font_mem [4096];
  logic [15:0] pal_mem  [256];

  // Instance A (NUM_COLS=100) and instance B (NUM_COLS=2).
  logic        a_busy, a_done, a_chr_rd, a_font_rd, a_pal_rd, a_wr;
  logic [7:0]  a_chr_addr, a_pal_addr;
  logic [11:0] a_font_addr;
  logic [9:0]  a_wr_addr;
  logic [15:0] a_wr_data, a_chr_q, a_pal_q;
  logic [7:0]  a_font_q;
  logic        b_busy, b_done, b_chr_rd, b_font_rd, b_pal_rd, b_wr;
  logic [7:0]  b_chr_addr, b_pal_addr;
  logic [11:0] b_font_addr;
  logic [9:0]  b_wr_addr;
  logic [15:0] b_wr_data, b_chr_q, b_pal_q;
  logic [7:0]  b_font_q;

  char_renderer #(.NUM_COLS(100)) dut_a (
    .clk(clk), .nrst(nrst), .start(start & ~sel), .pixel_row(pixel_row),
    .busy(a_busy), .done(a_done),
    .chrowbuf_rd(a_chr_rd), .chrowbuf_rd_addr(a_chr_addr), .chrowbuf_rd_data(a_chr_q),
    .fontmem_rd(a_font_rd), .fontmem_rd_addr(a_font_addr), .fontmem_rd_data(a_font_q),
    .palette_rd(a_pal_rd), .palette_rd_addr(a_pal_addr), .palette_rd_data(a_pal_q),
    .pixbuf_wr(a_wr), .pixbuf_wr_addr(a_wr_addr), .pixbuf_wr_data(a_wr_data)
  );

  char_renderer #(.NUM_COLS(2)) dut_b (
    .clk(clk), .nrst(nrst), .start(start & sel), .pixel_row(pixel_row),
    .busy(b_busy), .done(b_done),
    .chrowbuf_rd(b_chr_rd), .chrowbuf_rd_addr(b_chr_addr), .chrowbuf_rd_data(b_chr_q),
    .fontmem_rd(b_font_rd), .fontmem_rd_addr(b_font_addr), .fontmem_rd_data(b_font_q),
    .palette_rd(b_pal_rd), .palette_rd_addr(b_pal_addr), .palette_rd_data(b_pal_q),
    .pixbuf_wr(b_wr), .pixbuf_wr_addr(b_wr_addr), .pixbuf_wr_data(b_wr_data)
  );

  // One-cycle-latency synchronous read ports.
  always @(posedge clk) begin
    if (!a_chr_rd)  a_chr_q  <= chr_mem[a_chr_addr];
    if (!a_font_rd) a_font_q <= font_mem[a_font_addr];
    if (!a_pal_rd)  a_pal_q  <= pal_mem[a_pal_addr];
    if (!b_chr_rd)  b_chr_q  <= chr_mem[b_chr_addr];
    if (!b_font_rd) b_font_q <= font_mem[b_font_addr];
    if (!b_pal_rd)  b_pal_q  <= pal_mem[b_pal_addr];
  end

  // Observed instance selection.
  logic        d_busy, d_done, d_chr_rd, d_font_rd, d_wr;
  logic [7:0]  d_chr_addr;
  logic [11:0] d_font_addr;
  logic [9:0]  d_wr_addr;
  logic [15:0] d_wr_data;
  assign d_busy      = sel ? b_busy      : a_busy;
  assign d_done      = sel ? b_done      : a_done;
  assign d_chr_rd    = sel ? b_chr_rd    : a_chr_rd;
  assign d_font_rd   = sel ? b_font_rd   : a_font_rd;
  assign d_wr        = sel ? b_wr        : a_wr;
  assign d_chr_addr  = sel ? b_chr_addr  : a_chr_addr;
  assign d_font_addr = sel ? b_font_addr : a_font_addr;
  assign d_wr_addr   = sel ? b_wr_addr   : a_wr_addr;
  assign d_wr_data   = sel ? b_wr_data   : a_wr_data;

  // Scoreboard queues.
  logic [25:0] exp_wr[$];
  logic [11:0] exp_font[$];
  logic [7:0]  exp_chr[$];
  int          exp_done[$];
  int          exp_lat[$];
  logic [15:0] hand8 [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_msg(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: pop and compare whenever the DUT presents an event.
  logic [25:0] m_e;
  int          m_run = 0;
  always @(negedge clk) begin
    if (!d_wr) begin
      if (exp_wr.size() == 0) fail_msg($sformatf("wr_extra addr %0d", d_wr_addr));
      else begin
        m_e = exp_wr.pop_front();
        chk("wr_addr", 32'(d_wr_addr), 32'(m_e[25:16]));
        chk($sformatf("wr_data@%0d", m_e[25:16]), 32'(d_wr_data), 32'(m_e[15:0]));
      end
      if (d_wr_addr == 10'd0) begin
        if (exp_lat.size() == 0) fail_msg("first_wr_unexpected");
        else chk("first_wr_cycle", 32'(cyc), 32'(exp_lat.pop_front()));
      end
    end
    if (!d_font_rd) begin
      if (exp_font.size() == 0) fail_msg($sformatf("font_rd_extra addr %0h", d_font_addr));
      else chk("font_addr", 32'(d_font_addr), 32'(exp_font.pop_front()));
    end
    if (!d_chr_rd) begin
      if (exp_chr.size() == 0) fail_msg($sformatf("chr_rd_extra addr %0d", d_chr_addr));
      else chk("chr_addr", 32'(d_chr_addr), 32'(exp_chr.pop_front()));
    end
    if (!nrst) m_run = 0;
    else if (d_busy) m_run++;
    if (d_done) begin
      if (exp_done.size() == 0) fail_msg("done_extra");
      else chk("busy_cycles", 32'(m_run), 32'(exp_done.pop_front()));
      chk("busy_in_done", 32'(d_busy), 32'd0);
      m_run = 0;
    end
  end

  // Expected line from the hand-computed 8-pixel pattern in hand8.
  task automatic push_hand(input int n, input logic [3:0] row, input logic [7:0] code);
    for (int k = 0; k < n; k++) begin
      exp_chr.push_back(8'(k));
      exp_font.push_back({code, row});
      for (int b = 0; b < 8; b++) exp_wr.push_back({10'(8 * k + b), hand8[b]});
    end
  endtask

  // Expected line computed from memory contents.
  task automatic push_model(input int n, input logic [3:0] row);
    logic [15:0] w;
    logic [7:0]  p;
    logic [11:0] c;
    for (int k = 0; k < n; k++) begin
      w = chr_mem[k];
      p = font_mem[{w[7:0], row}];
      exp_chr.push_back(8'(k));
      exp_font.push_back({w[7:0], row});
      for (int b = 0; b < 8; b++) begin
        c = p[7 - b] ? pal_mem[w[11:8]][11:0] : pal_mem[w[15:12]][11:0];
        exp_wr.push_back({10'(8 * k + b), 4'h0, c});
      end
    end
  endtask

  // Issue start at a negedge; first write expected 7 negedges later.
  task automatic issue(input logic [3:0] row, input int n);
    start = 1'b1;
    pixel_row = row;
    exp_lat.push_back(cyc + 7);
    exp_done.push_back(8 * n + 6);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (!d_done && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (!d_done) fail_msg("done_timeout");
  endtask

  task automatic wait_write(input logic [9:0] addr, input int budget);
    int i;
    i = 0;
    while (!(d_wr == 1'b0 && d_wr_addr == addr) && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (!(d_wr == 1'b0 && d_wr_addr == addr)) fail_msg("write_timeout");
  endtask

  task automatic check_empty(input string tag);
    chk({tag, "_wr_left"},   32'(exp_wr.size()),   32'd0);
    chk({tag, "_font_left"}, 32'(exp_font.size()), 32'd0);
    chk({tag, "_chr_left"},  32'(exp_chr.size()),  32'd0);
    chk({tag, "_done_left"}, 32'(exp_done.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      chr_mem[i] = 16'h0;
      pal_mem[i] = 16'h0;
    end
    for (int i = 0; i < 4096; i++) font_mem[i] = 8'h0;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_wr",        32'(a_wr),        32'd1);
    chk("rst_chr_rd",    32'(a_chr_rd),    32'd1);
    chk("rst_font_rd",   32'(a_font_rd),   32'd1);
    chk("rst_pal_rd",    32'(a_pal_rd),    32'd1);
    chk("rst_chr_addr",  32'(a_chr_addr),  32'd0);
    chk("rst_font_addr", 32'(a_font_addr), 32'd0);
    chk("rst_pal_addr",  32'(a_pal_addr),  32'd0);
    chk("rst_wr_addr",   32'(a_wr_addr),   32'd0);
    chk("rst_wr_data",   32'(a_wr_data),   32'd0);
    chk("rst_busy",      32'(a_busy),      32'd0);
    chk("rst_done",      32'(a_done),      32'd0);
    chk("rst_b_wr",      32'(b_wr),        32'd1);
    nrst = 1'b1;
    @(negedge clk);

    // Baseline line, with an ignored start at write 200.
    for (int i = 0; i < 256; i++) chr_mem[i] = 16'h1241;
    font_mem[{8'h41, 4'd3}] = 8'b1000_1010;
    font_mem[{8'h41, 4'd4}] = 8'b1111_0000;
    pal_mem[1] = 16'h0004;
    pal_mem[2] = 16'h0cc0;
    hand8 = '{16'h0cc0, 16'h0004, 16'h0004, 16'h0004, 16'h0cc0, 16'h0004, 16'h0cc0, 16'h0004};
    push_hand(100, 4'd3, 8'h41);
    issue(4'd3, 100);
    wait_write(10'd200, 1000);
    start = 1'b1;
    pixel_row = 4'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000);

    // Back-to-back: start in the done cycle with row 4.
    hand8 = '{16'h0cc0, 16'h0cc0, 16'h0cc0, 16'h0cc0, 16'h0004, 16'h0004, 16'h0004, 16'h0004};
    push_hand(100, 4'd4, 8'h41);
    issue(4'd4, 100);
    wait_done(2000);
    repeat (3) @(negedge clk);
    check_empty("line12");

    // Per-cell addressing, aborted by reset at write 400.
    for (int i = 0; i < 256; i++) begin
      chr_mem[i] = {4'h0, 4'hF, 8'(i)};
      font_mem[{8'(i), 4'd5}] = 8'(i * 37 + 11);
    end
    pal_mem[0]  = 16'h0123;
    pal_mem[15] = 16'h0abc;
    push_model(100, 4'd5);
    issue(4'd5, 100);
    wait_write(10'd400, 1000);
    nrst = 1'b0;
    @(negedge clk);
    chk("abort_wr",      32'(a_wr),      32'd1);
    chk("abort_busy",    32'(a_busy),    32'd0);
    chk("abort_done",    32'(a_done),    32'd0);
    chk("abort_chr_rd",  32'(a_chr_rd),  32'd1);
    chk("abort_wr_addr", 32'(a_wr_addr), 32'd0);
    exp_wr.delete();
    exp_font.delete();
    exp_chr.delete();
    exp_done.delete();
    exp_lat.delete();
    nrst = 1'b1;
    repeat (5) @(negedge clk);

    // Full line after the abort.
    push_model(100, 4'd5);
    issue(4'd5, 100);
    wait_done(2000);
    repeat (3) @(negedge clk);
    check_empty("line3");

    // NUM_COLS=2 instance.
    sel = 1'b1;
    for (int i = 0; i < 256; i++) chr_mem[i] = 16'h1241;
    hand8 = '{16'h0cc0, 16'h0004, 16'h0004, 16'h0004, 16'h0cc0, 16'h0004, 16'h0cc0, 16'h0004};
    push_hand(2, 4'd3, 8'h41);
    issue(4'd3, 2);
    wait_done(100);
    chk("small_last_addr", 32'(b_wr_addr), 32'd15);
    repeat (3) @(negedge clk);
    check_empty("small");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
